// File: rtl/alu_ctrl_unit.sv
// ALU control decode for the MIPS execute stage: ALUOp + funct -> registered ALU select.
// Optional macro ALU_CTRL_EXT_OPS_EN adds nor/xor/sltu decode (ALUctrl 011/100/101).
module alu_ctrl_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] funct,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUctrl,
  output logic       illegal_funct
);

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_SLT  = 3'b111;
`ifdef ALU_CTRL_EXT_OPS_EN
  localparam logic [2:0] CTRL_NOR  = 3'b011;
  localparam logic [2:0] CTRL_XOR  = 3'b100;
  localparam logic [2:0] CTRL_SLTU = 3'b101;
`endif

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ORI    = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
`ifdef ALU_CTRL_EXT_OPS_EN
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLTU = 6'b101011;
`endif

  logic [2:0] ctrl_s;
  logic       illegal_s;
  logic [2:0] ctrl_r;
  logic       illegal_r;

  // Next-value decode; unsupported R-type codes fall back to ADD and raise illegal.
  always_comb begin
    ctrl_s    = CTRL_ADD;
    illegal_s = 1'b0;
    case (ALUOp)
      OP_MEM: begin
        ctrl_s    = CTRL_ADD;
        illegal_s = 1'b0;
      end
      OP_BRANCH: begin
        ctrl_s    = CTRL_SUB;
        illegal_s = 1'b0;
      end
      OP_ORI: begin
        ctrl_s    = CTRL_OR;
        illegal_s = 1'b0;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin
            ctrl_s    = CTRL_ADD;
            illegal_s = 1'b0;
          end
          FN_SUB, FN_SUBU: begin
            ctrl_s    = CTRL_SUB;
            illegal_s = 1'b0;
          end
          FN_AND: begin
            ctrl_s    = CTRL_AND;
            illegal_s = 1'b0;
          end
          FN_OR: begin
            ctrl_s    = CTRL_OR;
            illegal_s = 1'b0;
          end
          FN_SLT: begin
            ctrl_s    = CTRL_SLT;
            illegal_s = 1'b0;
          end
`ifdef ALU_CTRL_EXT_OPS_EN
          FN_NOR: begin
            ctrl_s    = CTRL_NOR;
            illegal_s = 1'b0;
          end
          FN_XOR: begin
            ctrl_s    = CTRL_XOR;
            illegal_s = 1'b0;
          end
          FN_SLTU: begin
            ctrl_s    = CTRL_SLTU;
            illegal_s = 1'b0;
          end
`endif
          default: begin
            ctrl_s    = CTRL_ADD;
            illegal_s = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_s    = CTRL_ADD;
        illegal_s = 1'b0;
      end
    endcase
  end

  // Output register; reset wins over en, en=0 holds the last decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_r    <= CTRL_ADD;
      illegal_r <= 1'b0;
    end else if (en) begin
      ctrl_r    <= ctrl_s;
      illegal_r <= illegal_s;
    end else begin
      ctrl_r    <= ctrl_r;
      illegal_r <= illegal_r;
    end
  end

  assign ALUctrl       = ctrl_r;
  assign illegal_funct = illegal_r;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Self-checking bench for alu_ctrl_unit: directed scenarios plus randomized traffic
// checked against a table-driven reference model.
module tb_alu_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [5:0] funct;
  logic [1:0] ALUOp;
  logic [2:0] ALUctrl;
  logic       illegal_funct;

  int checks = 0;
  int errors = 0;

  alu_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .funct(funct), .ALUOp(ALUOp),
    .ALUctrl(ALUctrl), .illegal_funct(illegal_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Legal R-type funct codes and the operation each one selects.
`ifdef ALU_CTRL_EXT_OPS_EN
  localparam int NLEGAL = 10;
  logic [5:0] legal_fn  [NLEGAL] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h26, 6'h2B};
  logic [2:0] legal_op  [NLEGAL] = '{3'd2, 3'd2, 3'd6, 3'd6, 3'd0, 3'd1, 3'd7, 3'd3, 3'd4, 3'd5};
`else
  localparam int NLEGAL = 7;
  logic [5:0] legal_fn  [NLEGAL] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
  logic [2:0] legal_op  [NLEGAL] = '{3'd2, 3'd2, 3'd6, 3'd6, 3'd0, 3'd1, 3'd7};
`endif

  // Reference decode: fixed ops for non-R-type, table lookup for R-type.
  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return {3'd2, 1'b0};
    if (op == 2'b01) return {3'd6, 1'b0};
    if (op == 2'b11) return {3'd1, 1'b0};
    for (int i = 0; i < NLEGAL; i++)
      if (legal_fn[i] == f) return {legal_op[i], 1'b0};
    return {3'd2, 1'b1};
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] op, input logic [5:0] f);
    @(negedge clk);
    rst_n = r; en = e; ALUOp = op; funct = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 2'b10, 6'h3F);
    checks++;
    if (ALUctrl !== 3'b010 || illegal_funct !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ctrl=%b ill=%b, expected ctrl=010 ill=0", ALUctrl, illegal_funct);
    end
    step(1'b0, 1'b1, 2'b10, 6'h2A);
    checks++;
    if (ALUctrl !== 3'b010 || illegal_funct !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_en: got ctrl=%b ill=%b, expected ctrl=010 ill=0", ALUctrl, illegal_funct);
    end
  endtask

  task automatic test_rtype;
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] exp [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'b10, fns[i]);
      checks++;
      if (ALUctrl !== exp[i] || illegal_funct !== 1'b0) begin
        errors++;
        $display("FAIL rtype_%b: got ctrl=%b ill=%b, expected ctrl=%b ill=0", fns[i], ALUctrl, illegal_funct, exp[i]);
      end
    end
  endtask

  task automatic test_fixed_ops;
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b11};
    logic [2:0] exp [3] = '{3'b010, 3'b110, 3'b001};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, ops[i], 6'b101010);
      checks++;
      if (ALUctrl !== exp[i] || illegal_funct !== 1'b0) begin
        errors++;
        $display("FAIL fixed_op_%b: got ctrl=%b ill=%b, expected ctrl=%b ill=0", ops[i], ALUctrl, illegal_funct, exp[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [2:0] exp_c;
    logic       exp_i;
`ifdef ALU_CTRL_EXT_OPS_EN
    exp_c = 3'b011; exp_i = 1'b0;
`else
    exp_c = 3'b010; exp_i = 1'b1;
`endif
    step(1'b1, 1'b1, 2'b10, 6'b100111);
    checks++;
    if (ALUctrl !== exp_c || illegal_funct !== exp_i) begin
      errors++;
      $display("FAIL nor_code: got ctrl=%b ill=%b, expected ctrl=%b ill=%b", ALUctrl, illegal_funct, exp_c, exp_i);
    end
    step(1'b1, 1'b1, 2'b10, 6'b000000);
    checks++;
    if (ALUctrl !== 3'b010 || illegal_funct !== 1'b1) begin
      errors++;
      $display("FAIL illegal_000000: got ctrl=%b ill=%b, expected ctrl=010 ill=1", ALUctrl, illegal_funct);
    end
    step(1'b1, 1'b1, 2'b01, 6'b000000);
    checks++;
    if (ALUctrl !== 3'b110 || illegal_funct !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear_nonrtype: got ctrl=%b ill=%b, expected ctrl=110 ill=0", ALUctrl, illegal_funct);
    end
  endtask

  task automatic test_hold;
    step(1'b1, 1'b1, 2'b10, 6'b101010);
    checks++;
    if (ALUctrl !== 3'b111) begin
      errors++;
      $display("FAIL hold_load: got ctrl=%b, expected 111", ALUctrl);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'b00, 6'b000000);
      checks++;
      if (ALUctrl !== 3'b111 || illegal_funct !== 1'b0) begin
        errors++;
        $display("FAIL hold_en0_%0d: got ctrl=%b ill=%b, expected ctrl=111 ill=0", i, ALUctrl, illegal_funct);
      end
    end
    step(1'b1, 1'b1, 2'b00, 6'b000000);
    checks++;
    if (ALUctrl !== 3'b010) begin
      errors++;
      $display("FAIL hold_release: got ctrl=%b, expected 010", ALUctrl);
    end
  endtask

  task automatic test_random;
    logic [3:0] model;
    logic       r, e;
    logic [1:0] op;
    logic [5:0] f;
    model = {ALUctrl, illegal_funct};  // state is known after test_hold's checks
    model = {3'b010, 1'b0};
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 15) != 0);
      e  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) f = 6'($urandom_range(32, 47));
      else f = 6'($urandom);
      step(r, e, op, f);
      if (!r) model = {3'b010, 1'b0};
      else if (e) model = ref_decode(op, f);
      checks++;
      if ({ALUctrl, illegal_funct} !== model) begin
        errors++;
        $display("FAIL random_%0d (rst_n=%b en=%b op=%b f=%b): got ctrl=%b ill=%b, expected ctrl=%b ill=%b",
                 i, r, e, op, f, ALUctrl, illegal_funct, model[3:1], model[0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; funct = 6'd0; ALUOp = 2'b00;
    test_reset();
    test_rtype();
    test_fixed_ops();
    test_illegal();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
